seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parameterised Moore sequence detector, the successor to the fixed 4-bit FSM detectors in RTL/FSM. It takes a pattern and length at run time, selectable overlap or non-overlap matching, and a valid qualifier on the serial input. It raises a registered one-cycle match pulse and keeps a saturating match count. It sits on a serial bit stream inside protocol/framing logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
LEN_W, 4, width of pat_len; must hold MAX_LEN.
CNT_W, 8, width of match_cnt.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
cfg_load  input  1  latch pattern/pat_len/overlap this cycle
pattern  input  MAX_LEN  target bits; pattern[pat_len-1] is first bit received, pattern[0] is last
pat_len  input  LEN_W  pattern length, legal 1..MAX_LEN
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
x_valid  input  1  x is sampled only when high
x  input  1  serial data bit
z  output  1  registered match pulse (Moore)
match_cnt  output  CNT_W  saturating count of matches since reset/cfg_load
cfg_err  output  1  last cfg_load had illegal pat_len
active  output  1  FSM in RUN

Behaviour:
- Reset (async, rst=1): FSM=IDLE. History, fill count, latched config and match_cnt = 0. z=0, cfg_err=0, active=0.
- FSM states: IDLE, RUN.
  - IDLE: x ignored, z=0.
  - cfg_load=1 in either state: latch pattern/pat_len/overlap; clear history, fill and match_cnt; z=0 next cycle.
  - Next state after cfg_load: RUN if 1<=pat_len<=MAX_LEN (cfg_err<=0), else IDLE (cfg_err<=1).
  - cfg_load has priority over a simultaneous x_valid; that bit is dropped.
- RUN, x_valid=1:
  - history <= {history[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
  - Match when fill_next >= pat_len and history_next[pat_len-1:0] == pattern[pat_len-1:0]. Compare uses only the low pat_len bits.
- Moore output: z is a register, high for exactly the one cycle after the clock edge that sampled the final pattern bit; otherwise 0.
- On match:
  - overlap=1: fill is kept, so the suffix can start the next match.
  - overlap=0: fill <= 0. History bits remain but are ignored until fill reaches pat_len again.
- RUN, x_valid=0: history, fill and z hold their values except z, which goes to 0. No match can occur.
- match_cnt increments on every match and saturates at 2^CNT_W-1 (no wrap).
- pat_len=1: every valid bit equal to pattern[0] matches, in both modes.
- rst asserted mid-stream: immediate return to reset values; a partial match is lost.

Optional Feature:
Macro SEQ_DET_CNT_EN.
- Defined: match_cnt is implemented as above.
- Undefined: counter logic is removed and match_cnt is tied to 0. The port remains.

Test Plan:
- Reset mid-stream: rst pulsed between clock edges while fill=3 -> outputs clear immediately, no z afterwards until a full new pattern arrives.
- cfg pattern=8'b0000_1010, pat_len=4, overlap=1, valid bits 1,0,1,0,1,0 -> z high the cycle after bit 4 and after bit 6; match_cnt=2.
- Same pattern, overlap=0, bits 1,0,1,0,1,0,1,0 -> z after bit 4 and bit 8 only; match_cnt=2.
- pattern=0110, len=4, overlap=1, bits 0,1,1,0,1,1,0 -> z after bits 4 and 7. Insert x_valid=0 gaps between bits -> same matches, z never high on a gap cycle.
- cfg_load with pat_len=0, then pat_len=MAX_LEN+1 -> cfg_err=1, active=0, z stays 0. Then a legal cfg_load -> cfg_err=0, active=1.
- CNT_W=2, pat_len=1, pattern[0]=1, five valid 1s -> z high five consecutive cycles, match_cnt stops at 3. With SEQ_DET_CNT_EN undefined -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: configuration, serial-input and result signals of
// the parameterised sequence detector, grouped into one bundle.
// master = the side that drives configuration and serial data,
// slave  = the detector itself.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) ();
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               x_valid;
    logic               x;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;
    logic               active;

    modport master (
        output cfg_load, pattern, pat_len, overlap, x_valid, x,
        input  z, match_cnt, cfg_err, active
    );

    modport slave (
        input  cfg_load, pattern, pat_len, overlap, x_valid, x,
        output z, match_cnt, cfg_err, active
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable Moore sequence detector.
// Pattern, length and overlap mode are latched on cfg_load; serial bits are
// shifted in on x_valid and a registered one-cycle pulse z marks each match.
// Optional feature macro: SEQ_DET_CNT_EN -- when defined, match_cnt is a
// saturating match counter; when undefined the counter is absent and
// match_cnt is tied to 0.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    seq_detector_param_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state_reg, state_next;

    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               ovl_reg;
    logic               cfg_err_reg;
    logic [MAX_LEN-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0]   fill_reg, fill_next, fill_inc;
    logic               z_reg, z_next;
    logic               match;
    logic               cfg_ok;
    logic [MAX_LEN-1:0] len_mask;

    // A length is usable only if it selects at least one and at most MAX_LEN bits.
    assign cfg_ok = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(MAX_LEN));

    // Mask of the low len_reg bits: only those take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: only a configuration load moves the FSM.
    always_comb begin
        state_next = state_reg;
        if (bus.cfg_load)
            state_next = cfg_ok ? RUN : IDLE;
    end

    // Output / datapath logic: shift, fill tracking and match decision.
    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        fill_inc  = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + LEN_W'(1);
        match     = 1'b0;
        z_next    = 1'b0;
        if (bus.cfg_load) begin
            // A simultaneous valid bit is deliberately dropped here.
            hist_next = '0;
            fill_next = '0;
        end else if (state_reg == RUN && bus.x_valid) begin
            hist_next = {hist_reg[MAX_LEN-2:0], bus.x};
            match     = (fill_inc >= len_reg) &&
                        (((hist_next ^ pat_reg) & len_mask) == '0);
            // Non-overlap restarts filling so no bit is shared between matches.
            fill_next = (match && !ovl_reg) ? '0 : fill_inc;
            z_next    = match;
        end
    end

    // Datapath and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg     <= '0;
            len_reg     <= '0;
            ovl_reg     <= 1'b0;
            cfg_err_reg <= 1'b0;
            hist_reg    <= '0;
            fill_reg    <= '0;
            z_reg       <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                pat_reg     <= bus.pattern;
                len_reg     <= bus.pat_len;
                ovl_reg     <= bus.overlap;
                cfg_err_reg <= !cfg_ok;
            end
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            z_reg    <= z_next;
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Saturating match counter, cleared by every configuration load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if (bus.cfg_load)
            cnt_reg <= '0;
        else if (match && cnt_reg != '1)
            cnt_reg <= cnt_reg + CNT_W'(1);
    end

    assign bus.match_cnt = cnt_reg;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.z       = z_reg;
    assign bus.cfg_err = cfg_err_reg;
    assign bus.active  = (state_reg == RUN);
endmodule
